// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 640x480 VGA sprite-overlay path:
//   - default active-area geometry
//   - RGB565 colour constants used by the colour-bar background
//   - overlay mode encodings
//   - bar_colour(): maps a bar index (0..9) to its RGB565 colour
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VALID_DEF = 640;
    localparam int V_VALID_DEF = 480;

    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] ORANGE = 16'hFC00;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] CYAN   = 16'h07FF;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] PURPLE = 16'hF81F;
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GRAY   = 16'hD69A;

    typedef enum logic [1:0] {
        MODE_BG     = 2'd0,   // background only, image hidden
        MODE_OPAQUE = 2'd1,   // image drawn with palette colours
        MODE_TRANSP = 2'd2,   // palette index 0 shows the background
        MODE_INVERT = 2'd3    // image drawn with inverted palette colours
    } mode_t;

    // Colour for bar index 0..9 in display order.
    function automatic logic [15:0] bar_colour(input logic [3:0] idx);
        logic [15:0] c;
        case (idx)
            4'd0:    c = RED;
            4'd1:    c = ORANGE;
            4'd2:    c = YELLOW;
            4'd3:    c = GREEN;
            4'd4:    c = CYAN;
            4'd5:    c = BLUE;
            4'd6:    c = PURPLE;
            4'd7:    c = BLACK;
            4'd8:    c = WHITE;
            4'd9:    c = GRAY;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_bar_bg.sv
// ----------------------------------------------------------------------------
// vga_bar_bg
// Registered vertical colour-bar background generator. The colour for pix_x
// appears on bg one clock later, which lines it up with the ROM read data.
// Ports:
//   clk    in   pixel clock
//   rst_n  in   async reset, active low (bg cleared to black)
//   pix_x  in   10-bit current x; >= H_VALID is outside the active area
//   bg     out  16-bit RGB565 background colour (registered)
// ----------------------------------------------------------------------------
module vga_bar_bg
    import vga_pkg::*;
#(
    parameter int H_VALID = 640,
    parameter int NBARS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    output logic [15:0] bg
);

    localparam int BAR_W = H_VALID / NBARS;

    logic [9:0] band_s;
    logic [3:0] colour_idx_s;

    // Bar index of the current pixel; bars beyond the tenth reuse the sequence.
    always_comb begin
        band_s       = pix_x / 10'(BAR_W);
        colour_idx_s = 4'(band_s % 10'd10);
    end

    // Background colour register, black outside the active line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg <= BLACK;
        end else if ({1'b0, pix_x} >= 11'(H_VALID)) begin
            bg <= BLACK;
        end else begin
            bg <= bar_colour(colour_idx_s);
        end
    end

endmodule

// File: rtl/vga_sprite_overlay.sv
// ----------------------------------------------------------------------------
// vga_sprite_overlay
// Composites a ROM-stored indexed-colour image over a colour-bar background.
// Position and mode are sampled only during vertical blanking so a frame is
// never torn. The ROM address is a raster counter rather than a multiply.
// Ports:
//   vga_clk       in   pixel clock
//   sys_rst_n     in   async reset, active low
//   pix_x, pix_y  in   current pixel coordinate (>= H_VALID/V_VALID outside)
//   pos_x, pos_y  in   requested image top-left corner
//   mode          in   0 bg only, 1 opaque, 2 index-0 transparent, 3 inverted
//   rom_addr      out  ROM address (registered counter)
//   rom_rden      out  ROM read enable (current pixel inside the image)
//   rom_data      in   palette index, valid one cycle after the read
//   pix_data_out  out  RGB565 pixel, one cycle behind pix_x/pix_y
// ----------------------------------------------------------------------------
module vga_sprite_overlay
    import vga_pkg::*;
#(
    parameter int          H_VALID = 640,
    parameter int          V_VALID = 480,
    parameter int          PIC_W   = 320,
    parameter int          PIC_H   = 240,
    parameter int          BPP     = 2,
    parameter int          AW      = 17,
    parameter int          NBARS   = 10,
    parameter logic [15:0] PAL0    = 16'h0000,
    parameter logic [15:0] PAL1    = 16'hFFFF,
    parameter logic [15:0] PAL2    = 16'hF800,
    parameter logic [15:0] PAL3    = 16'h001F
) (
    input  logic           vga_clk,
    input  logic           sys_rst_n,
    input  logic [9:0]     pix_x,
    input  logic [9:0]     pix_y,
    input  logic [9:0]     pos_x,
    input  logic [9:0]     pos_y,
    input  logic [1:0]     mode,
    output logic [AW-1:0]  rom_addr,
    output logic           rom_rden,
    input  logic [BPP-1:0] rom_data,
    output logic [15:0]    pix_data_out
);

    localparam int X_MAX    = H_VALID - PIC_W;
    localparam int Y_MAX    = V_VALID - PIC_H;
    localparam int PIX_LAST = PIC_W * PIC_H - 1;

    function automatic logic [15:0] pal_lookup(input logic [1:0] idx);
        logic [15:0] c;
        case (idx)
            2'd0:    c = PAL0;
            2'd1:    c = PAL1;
            2'd2:    c = PAL2;
            2'd3:    c = PAL3;
            default: c = PAL0;
        endcase
        return c;
    endfunction

    logic [9:0]    px_r;
    logic [9:0]    py_r;
    mode_t         mode_r;
    logic [AW-1:0] addr_r;
    logic          win_d_r;
    mode_t         mode_d_r;

    logic          blank_s;
    logic [9:0]    px_next_s;
    logic [9:0]    py_next_s;
    logic          in_win_s;
    logic [1:0]    idx_s;
    logic [15:0]   pal_s;
    logic [15:0]   bg_s;

    // Blanking detect and clamp so the whole image always stays on screen;
    // the address counter relies on every image pixel being scanned.
    always_comb begin
        blank_s   = ({1'b0, pix_y} >= 11'(V_VALID));
        px_next_s = (pos_x > 10'(X_MAX)) ? 10'(X_MAX) : pos_x;
        py_next_s = (pos_y > 10'(Y_MAX)) ? 10'(Y_MAX) : pos_y;
    end

    // Image window test against the frame's latched origin.
    always_comb begin
        in_win_s = ({1'b0, pix_x} >= {1'b0, px_r})
                && ({1'b0, pix_x} <  ({1'b0, px_r} + 11'(PIC_W)))
                && ({1'b0, pix_y} >= {1'b0, py_r})
                && ({1'b0, pix_y} <  ({1'b0, py_r} + 11'(PIC_H)))
                && (mode_r != MODE_BG);
    end

    assign rom_rden = in_win_s;
    assign rom_addr = addr_r;

    // Frame configuration latch, open only while in vertical blanking.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            px_r   <= 10'd0;
            py_r   <= 10'd0;
            mode_r <= MODE_BG;
        end else if (blank_s) begin
            px_r   <= px_next_s;
            py_r   <= py_next_s;
            mode_r <= mode_t'(mode);
        end else begin
            px_r   <= px_r;
            py_r   <= py_r;
            mode_r <= mode_r;
        end
    end

    // Raster address counter: steps once per image pixel, restarts each frame.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_r <= {AW{1'b0}};
        end else if (blank_s) begin
            addr_r <= {AW{1'b0}};
        end else if (in_win_s) begin
            if (addr_r == AW'(PIX_LAST)) begin
                addr_r <= {AW{1'b0}};
            end else begin
                addr_r <= addr_r + AW'(1);
            end
        end else begin
            addr_r <= addr_r;
        end
    end

    // Delay window flag and mode to align with the ROM read data.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_d_r  <= 1'b0;
            mode_d_r <= MODE_BG;
        end else begin
            win_d_r  <= in_win_s;
            mode_d_r <= mode_r;
        end
    end

    vga_bar_bg #(
        .H_VALID (H_VALID),
        .NBARS   (NBARS)
    ) u_bar_bg (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .pix_x (pix_x),
        .bg    (bg_s)
    );

    // Final pixel mux; with BPP=1 the index is zero-extended so only PAL0/PAL1 occur.
    always_comb begin
        idx_s        = 2'(rom_data);
        pal_s        = pal_lookup(idx_s);
        pix_data_out = bg_s;
        if (!win_d_r) begin
            pix_data_out = bg_s;
        end else if ((mode_d_r == MODE_TRANSP) && (idx_s == 2'd0)) begin
            pix_data_out = bg_s;
        end else if (mode_d_r == MODE_INVERT) begin
            pix_data_out = ~pal_s;
        end else begin
            pix_data_out = pal_s;
        end
    end

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// ----------------------------------------------------------------------------
// tb_vga_sprite_overlay
// Randomised self-checking bench. A reduced image size keeps each frame
// short; only the rows crossing the image are scanned in full, other rows are
// sampled at a couple of random x positions. Expected pixels and addresses
// come from a coordinate-based reference model and a ROM array.
// ----------------------------------------------------------------------------
module tb_vga_sprite_overlay;

    localparam int W  = 64;
    localparam int H  = 32;
    localparam int N  = W * H;
    localparam int HV = 640;
    localparam int VV = 480;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [1:0]  mode;
    logic [16:0] rom_addr;
    logic        rom_rden;
    logic [1:0]  rom_data;
    logic [15:0] pix_data_out;

    logic [1:0]  rom_mem [0:N-1];

    int          n_checks;
    int          n_fail;

    // Reference-model frame configuration and pending output expectation.
    int          cpx, cpy, cmode;
    logic [15:0] prev_exp;
    bit          have_prev;

    vga_sprite_overlay #(
        .PIC_W (W),
        .PIC_H (H)
    ) dut (
        .vga_clk      (clk),
        .sys_rst_n    (rst_n),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .mode         (mode),
        .rom_addr     (rom_addr),
        .rom_rden     (rom_rden),
        .rom_data     (rom_data),
        .pix_data_out (pix_data_out)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Synchronous ROM: data appears one clock after a read request.
    always @(posedge clk) begin
        if (rom_rden && (rom_addr < 17'(N))) rom_data <= rom_mem[rom_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)",
                     tag, obs, expv, pix_x, pix_y, $time);
        end
    endtask

    function automatic logic [15:0] bar(input int x);
        if (x >= HV) return 16'h0000;
        case ((x / 64) % 10)
            0: return 16'hF800;
            1: return 16'hFC00;
            2: return 16'hFFE0;
            3: return 16'h07E0;
            4: return 16'h07FF;
            5: return 16'h001F;
            6: return 16'hF81F;
            7: return 16'h0000;
            8: return 16'hFFFF;
            default: return 16'hD69A;
        endcase
    endfunction

    function automatic logic [15:0] pal(input logic [1:0] i);
        case (i)
            2'd0: return 16'h0000;
            2'd1: return 16'hFFFF;
            2'd2: return 16'hF800;
            default: return 16'h001F;
        endcase
    endfunction

    function automatic bit in_image(input int x, input int y);
        return (cmode != 0) && (x >= cpx) && (x < cpx + W) && (y >= cpy) && (y < cpy + H);
    endfunction

    function automatic logic [15:0] exp_pix(input int x, input int y);
        logic [1:0] idx;
        if (!in_image(x, y)) return bar(x);
        idx = rom_mem[(y - cpy) * W + (x - cpx)];
        if (cmode == 2 && idx == 2'd0) return bar(x);
        if (cmode == 3) return ~pal(idx);
        return pal(idx);
    endfunction

    // Image pixels already scanned this frame, modulo the image size.
    function automatic int exp_addr(input int x, input int y);
        int cols;
        if (cmode == 0 || y >= VV || y < cpy || y >= cpy + H) return 0;
        cols = x - cpx;
        if (cols < 0) cols = 0;
        if (cols > W) cols = W;
        return ((y - cpy) * W + cols) % N;
    endfunction

    task automatic step(input int x, input int y);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        #2;
        if (have_prev) check_eq("pix_out", 32'(pix_data_out), 32'(prev_exp));
        check_eq("rom_rden", 32'(rom_rden), 32'(in_image(x, y)));
        check_eq("rom_addr", 32'(rom_addr), 32'(exp_addr(x, y)));
        prev_exp  = exp_pix(x, y);
        have_prev = 1'b1;
        if (y >= VV) begin
            cpx   = (int'(pos_x) > HV - W) ? HV - W : int'(pos_x);
            cpy   = (int'(pos_y) > VV - H) ? VV - H : int'(pos_y);
            cmode = int'(mode);
        end
    endtask

    task automatic reset_pulse(input int y);
        @(negedge clk);
        pix_x = 10'd300;
        pix_y = 10'(y);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            check_eq("rst_pix", 32'(pix_data_out), 32'h0);
            check_eq("rst_addr", 32'(rom_addr), 32'h0);
            check_eq("rst_rden", 32'(rom_rden), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_eq("post_rst_pix", 32'(pix_data_out), 32'h0);
        cpx   = 0;
        cpy   = 0;
        cmode = 0;
        check_eq("post_rst_rden", 32'(rom_rden), 32'h0);
        prev_exp  = exp_pix(300, y);
        have_prev = 1'b1;
    endtask

    task automatic visit_row(input int y);
        if (y >= cpy && y < cpy + H) begin
            if (cpx > 0) begin
                step($urandom_range(cpx - 1, 0), y);
                step(cpx - 1, y);
            end
            for (int x = cpx; x < cpx + W; x++) step(x, y);
            if (cpx + W < HV) begin
                step(cpx + W, y);
                step($urandom_range(HV - 1, cpx + W), y);
            end
        end else begin
            step($urandom_range(HV - 1, 0), y);
        end
        step($urandom_range(799, HV), y);
    endtask

    // kind 0: ROM holds addr%4, otherwise random indices.
    task automatic run_frame(input int bx, input int by, input int bm,
                             input int rst_row, input int chg_row,
                             input int cx, input int cy, input int cm, input int kind);
        pos_x = 10'(bx);
        pos_y = 10'(by);
        mode  = 2'(bm);
        step($urandom_range(799, 0), 490);
        for (int a = 0; a < N; a++) rom_mem[a] = (kind == 0) ? 2'(a % 4) : 2'($urandom);
        for (int b = 0; b < 5; b++) step($urandom_range(799, 0), $urandom_range(524, VV));
        for (int y = 0; y < VV; y++) begin
            if (y == chg_row) begin
                pos_x = 10'(cx);
                pos_y = 10'(cy);
                mode  = 2'(cm);
            end
            if (y == rst_row) reset_pulse(y);
            visit_row(y);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        have_prev = 1'b0;
        cpx = 0; cpy = 0; cmode = 0;
        rst_n = 1'b0;
        pix_x = 10'd0;
        pix_y = 10'd500;
        pos_x = 10'd0;
        pos_y = 10'd0;
        mode  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            check_eq("reset_pix", 32'(pix_data_out), 32'h0);
            check_eq("reset_addr", 32'(rom_addr), 32'h0);
            check_eq("reset_rden", 32'(rom_rden), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_eq("first_after_reset", 32'(pix_data_out), 32'h0);
        prev_exp  = exp_pix(0, 500);
        have_prev = 1'b1;

        run_frame(160, 120, 1, -1, -1, 0, 0, 0, 0);     // directed opaque, addr%4
        run_frame(160, 120, 1, -1, -1, 0, 0, 0, 1);     // counter restarts next frame
        run_frame(600, 470, 1, -1, -1, 0, 0, 0, 1);     // clamped to bottom-right
        run_frame(200, 150, 2, -1, -1, 0, 0, 0, 0);     // transparency
        run_frame(300, 100, 3, -1, -1, 0, 0, 0, 1);     // inverted
        run_frame(50, 60, 2, -1, 200, 10, 300, 3, 1);   // mid-frame change ignored
        run_frame(10, 300, 3, -1, -1, 0, 0, 0, 1);      // change applied
        run_frame(280, 180, 1, 200, -1, 0, 0, 0, 1);    // reset inside the image
        run_frame(280, 180, 1, -1, -1, 0, 0, 0, 1);     // recovery frame
        run_frame(100, 100, 0, -1, -1, 0, 0, 0, 1);     // background only
        for (int f = 0; f < 3; f++)
            run_frame($urandom_range(1023, 0), $urandom_range(1023, 0), $urandom_range(3, 0),
                      -1, -1, 0, 0, 0, 1);

        step(0, 490);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
